// File: rtl/mult_shift_add_seq_if.sv
// mult_shift_add_seq_if: host-side request/result bundle for the sequential multiplier
interface mult_shift_add_seq_if #(parameter int WIDTH = 16);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTH-1:0]   data_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  modport master (output start, signed_mode, data_a, data_b, input busy, done, product);
  modport slave  (input start, signed_mode, data_a, data_b, output busy, done, product);
endinterface

// File: rtl/mult_shift_add_seq.sv
// mult_shift_add_seq: radix-2 shift-and-add multiplier, signed/unsigned, early exit on empty multiplier
module mult_shift_add_seq #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst_n,
  mult_shift_add_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0]   mag_a, mag_b, mb, mb_sh;
  logic [2*WIDTH-1:0] mcand, acc, acc_sum;
  logic               neg, zero_op;
  // Magnitude of the most negative value wraps to itself, which reads correctly as unsigned.
  always_comb begin
    mag_a   = (bus.signed_mode && bus.data_a[WIDTH-1]) ? -bus.data_a : bus.data_a;
    mag_b   = (bus.signed_mode && bus.data_b[WIDTH-1]) ? -bus.data_b : bus.data_b;
    zero_op = (mag_a == '0) || (mag_b == '0);
    mb_sh   = mb >> 1;
    acc_sum = mb[0] ? acc + mcand : acc;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (bus.start ? (zero_op ? DONE : CALC) : IDLE) :
                (state == CALC) ? ((mb_sh == '0) ? DONE : CALC) : IDLE;
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      mb          <= '0;
      mcand       <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      bus.product <= '0;
    end else if (state == IDLE && bus.start) begin
      mb    <= mag_b;
      mcand <= {{WIDTH{1'b0}}, mag_a};
      acc   <= '0;
      neg   <= bus.signed_mode & (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]);
      if (zero_op) bus.product <= '0;
    end else if (state == CALC) begin
      acc   <= acc_sum;
      mcand <= mcand << 1;
      mb    <= mb_sh;
      if (mb_sh == '0) bus.product <= neg ? -acc_sum : acc_sum;
    end
endmodule

// File: tb/tb_mult_shift_add_seq.sv
// tb_mult_shift_add_seq: directed scenarios for the sequential multiplier
module tb_mult_shift_add_seq;
  logic clk, rst_n;
  int checks, failures;
  logic [31:0] last_prod;
  mult_shift_add_seq_if #(.WIDTH(16)) bus();
  mult_shift_add_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic run_op(input string name, input logic sm, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input int exp_n);
    int done_at, busy_n, pulses;
    logic held;
    logic [31:0] got, bad;
    bus.start = 1'b1; bus.signed_mode = sm; bus.data_a = a; bus.data_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.signed_mode = 1'($urandom); bus.data_a = 16'($urandom); bus.data_b = 16'($urandom);
    done_at = 0; busy_n = 0; pulses = 0; held = 1'b1; got = '0; bad = '0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        pulses++;
        if (done_at == 0) begin done_at = n; got = bus.product; end
      end else if (done_at == 0 && bus.product !== last_prod) begin
        held = 1'b0; bad = bus.product;
      end
      @(posedge clk); #1;
    end
    checks++; if (done_at !== exp_n) begin failures++; $display("FAIL %s latency: got %0d want %0d", name, done_at, exp_n); end
    checks++; if (got !== exp_p) begin failures++; $display("FAIL %s product: got %h want %h", name, got, exp_p); end
    checks++; if (busy_n !== exp_n) begin failures++; $display("FAIL %s busy cycles: got %0d want %0d", name, busy_n, exp_n); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL %s done pulses: got %0d want 1", name, pulses); end
    checks++; if (!held) begin failures++; $display("FAIL %s product hold: got %h want %h", name, bad, last_prod); end
    last_prod = exp_p;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.signed_mode = 1'b0; bus.data_a = '0; bus.data_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset done: got %b want 0", bus.done); end
    checks++; if (bus.product !== 32'h0) begin failures++; $display("FAIL reset product: got %h want 0", bus.product); end
    last_prod = '0;
  endtask
  task automatic test_unsigned;
    run_op("u17x5", 1'b0, 16'd17, 16'd5, 32'h0000_0055, 4);
    run_op("uffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 17);
    run_op("u1234x0", 1'b0, 16'd1234, 16'd0, 32'h0, 1);
  endtask
  task automatic test_signed;
    run_op("sm3x7", 1'b1, 16'hFFFD, 16'd7, 32'hFFFF_FFEB, 4);
    run_op("sminxmin", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 17);
    run_op("s5xm1", 1'b1, 16'd5, 16'hFFFF, 32'hFFFF_FFFB, 2);
  endtask
  task automatic test_start_held;
    int d1, d2, pulses;
    logic [31:0] p1, p2;
    logic idle_gap;
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.data_a = 16'd17; bus.data_b = 16'd5;
    @(posedge clk); #1;
    bus.data_a = 16'hFFFF; bus.data_b = 16'hFFFF;
    d1 = 0; d2 = 0; pulses = 0; p1 = '0; p2 = '0; idle_gap = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) idle_gap = bus.busy;
      if (bus.done) begin
        pulses++;
        if (d1 == 0) begin d1 = n; p1 = bus.product; end
        else if (d2 == 0) begin d2 = n; p2 = bus.product; end
      end
      if (n == 10) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (d1 !== 4 || p1 !== 32'h55) begin failures++; $display("FAIL held first op: got n=%0d p=%h want n=4 p=00000055", d1, p1); end
    checks++; if (idle_gap !== 1'b0) begin failures++; $display("FAIL held idle gap busy: got %b want 0", idle_gap); end
    checks++; if (d2 !== 22 || p2 !== 32'hFFFE_0001) begin failures++; $display("FAIL held second op: got n=%0d p=%h want n=22 p=fffe0001", d2, p2); end
    checks++; if (pulses !== 2) begin failures++; $display("FAIL held done pulses: got %0d want 2", pulses); end
    last_prod = 32'hFFFE_0001;
  endtask
  task automatic test_reset_mid_calc;
    int pulses;
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.data_a = 16'hFFFF; bus.data_b = 16'hFFFF;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL midreset flags: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.product !== 32'h0) begin failures++; $display("FAIL midreset product: got %h want 0", bus.product); end
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      if (bus.done) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL midreset stray done: got %0d want 0", pulses); end
    last_prod = '0;
    run_op("postreset17x5", 1'b0, 16'd17, 16'd5, 32'h55, 4);
  endtask
  task automatic test_back_to_back;
    run_op("b2b6x7", 1'b0, 16'd6, 16'd7, 32'd42, 4);
    run_op("b2b9x9", 1'b0, 16'd9, 16'd9, 32'd81, 5);
  endtask
  initial begin
    checks = 0; failures = 0;
    test_reset;
    test_unsigned;
    test_signed;
    test_start_held;
    test_reset_mid_calc;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
